// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W registers, one write port and two read ports.
// Latency: both read ports are registered, so data appears one CLK edge after the address.
// Backpressure: none. Every edge is accepted; there is no stall input and no ready output.
// Optional feature: define REGFILE_BYPASS_EN to forward IN to a read port whose address
// matches INADDRESS on a write edge. Otherwise that port returns the pre-write value.
module reg_file #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [DATA_W-1:0]    IN,
   input  logic [ADDR_W-1:0]    INADDRESS,
   input  logic                 WRITE,
   input  logic [ADDR_W-1:0]    OUT1ADDRESS,
   input  logic [ADDR_W-1:0]    OUT2ADDRESS,
   output logic [DATA_W-1:0]    OUT1,
   output logic [DATA_W-1:0]    OUT2,
   output logic                 OUT_VALID,
   output logic [2**ADDR_W-1:0] WRITTEN
);

   localparam int NREG = 2**ADDR_W;

   // Storage and registered outputs
   logic [DATA_W-1:0] r_regs [NREG];
   logic [DATA_W-1:0] r_out1;
   logic [DATA_W-1:0] r_out2;
   logic              r_out_valid;
   logic [NREG-1:0]   r_written;

   // Decoded write strobes and next read data
   logic [NREG-1:0]   w_wr_sel;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_hit1;
   logic              w_hit2;

   // One-hot write decode; the address is fully decoded, so every index is a real register
   always_comb begin
      w_wr_sel = '0;
      if (WRITE) begin
         w_wr_sel[INADDRESS] = 1'b1;
      end
   end

   // Read-port collision detection against the write port on this edge
   always_comb begin
      w_hit1 = WRITE && (OUT1ADDRESS == INADDRESS);
      w_hit2 = WRITE && (OUT2ADDRESS == INADDRESS);
   end

   // Read data selection: array contents are the pre-write values at this edge
   always_comb begin
      w_rd1 = r_regs[OUT1ADDRESS];
      w_rd2 = r_regs[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
      if (w_hit1) begin
         w_rd1 = IN;
      end
      if (w_hit2) begin
         w_rd2 = IN;
      end
`else
      // Without forwarding, a colliding read keeps the old value. The hit
      // terms are unused, so fold them into an expression with no effect.
      if (w_hit1 && 1'b0) begin
         w_rd1 = IN;
      end
      if (w_hit2 && 1'b0) begin
         w_rd2 = IN;
      end
`endif
   end

   // Register array update; reset wins over a simultaneous write
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_wr_sel[i]) begin
               r_regs[i] <= IN;
            end
         end
      end
   end

   // Sticky per-register written flags, cleared only by reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_written <= '0;
      end else begin
         r_written <= r_written | w_wr_sel;
      end
   end

   // Registered read ports and valid flag
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_out1      <= '0;
         r_out2      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out1      <= w_rd1;
         r_out2      <= w_rd2;
         r_out_valid <= 1'b1;
      end
   end

   assign OUT1      = r_out1;
   assign OUT2      = r_out2;
   assign OUT_VALID = r_out_valid;
   assign WRITTEN   = r_written;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, collision, reset priority, sweep.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants; the collision value follows the build macro.
module tb_reg_file;

   logic       CLK;
   logic       RESET;
   logic [7:0] IN;
   logic [2:0] INADDRESS;
   logic       WRITE;
   logic [2:0] OUT1ADDRESS;
   logic [2:0] OUT2ADDRESS;
   logic [7:0] OUT1;
   logic [7:0] OUT2;
   logic       OUT_VALID;
   logic [7:0] WRITTEN;

   int tests = 0;
   int fails = 0;

   reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .IN          (IN),
      .INADDRESS   (INADDRESS),
      .WRITE       (WRITE),
      .OUT1ADDRESS (OUT1ADDRESS),
      .OUT2ADDRESS (OUT2ADDRESS),
      .OUT1        (OUT1),
      .OUT2        (OUT2),
      .OUT_VALID   (OUT_VALID),
      .WRITTEN     (WRITTEN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      WRITE = 1'b1; INADDRESS = a; IN = d;
      step();
      WRITE = 1'b0;
   endtask

   logic [7:0] exp_coll;

   initial begin
`ifdef REGFILE_BYPASS_EN
      exp_coll = 8'h03;
`else
      exp_coll = 8'h35;
`endif
      RESET = 1'b1; IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0;
      OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;

      // Reset held for two edges
      step();
      step();
      check("rst_out1", OUT1, 8'h00);
      check("rst_out2", OUT2, 8'h00);
      check("rst_valid", OUT_VALID, 1'b0);
      check("rst_written", WRITTEN, 8'h00);

      // First non-reset edge
      RESET = 1'b0; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7;
      step();
      check("post_rst_out1", OUT1, 8'h00);
      check("post_rst_out2", OUT2, 8'h00);
      check("post_rst_valid", OUT_VALID, 1'b1);
      check("post_rst_written", WRITTEN, 8'h00);

      // Write/read
      wr(3'd1, 8'hFD);
      wr(3'd2, 8'h07);
      OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2;
      step();
      check("wr_out1", OUT1, 8'hFD);
      check("wr_out2", OUT2, 8'h07);
      check("wr_written", WRITTEN, 8'h06);

      // Collision on port 1, port 2 reads an untouched register
      wr(3'd5, 8'h35);
      OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd1;
      wr(3'd5, 8'h03);
      check("coll_out1", OUT1, exp_coll);
      check("coll_out2", OUT2, 8'hFD);
      check("coll_written", WRITTEN, 8'h26);
      step();
      check("coll_next_out1", OUT1, 8'h03);

      // WRITE=0 must not change a register
      IN = 8'hEE; INADDRESS = 3'd5; WRITE = 1'b0;
      step();
      step();
      check("nowrite_out1", OUT1, 8'h03);
      check("nowrite_written", WRITTEN, 8'h26);

      // Reset priority over a write
      RESET = 1'b1; WRITE = 1'b1; IN = 8'hAA; INADDRESS = 3'd4;
      step();
      check("rstpri_written", WRITTEN, 8'h00);
      check("rstpri_valid", OUT_VALID, 1'b0);
      RESET = 1'b0; WRITE = 1'b0; OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd1;
      step();
      check("rstpri_reg4", OUT1, 8'h00);
      check("rstpri_reg1_cleared", OUT2, 8'h00);
      check("rstpri_valid_after", OUT_VALID, 1'b1);
      check("rstpri_written_after", WRITTEN, 8'h00);

      // Same address on both ports, plus sticky rewrite
      wr(3'd0, 8'h22);
      wr(3'd0, 8'h11);
      OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
      step();
      check("same_out1", OUT1, 8'h11);
      check("same_out2", OUT2, 8'h11);
      check("same_written", WRITTEN, 8'h01);

      // Full sweep
      for (int i = 0; i < 8; i++) begin
         wr(i[2:0], 8'h10 + 8'(i));
      end
      check("sweep_written", WRITTEN, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = i[2:0];
         OUT2ADDRESS = 3'(7 - i);
         step();
         check($sformatf("sweep_p1_%0d", i), OUT1, 8'h10 + 8'(i));
         check($sformatf("sweep_p2_%0d", i), OUT2, 8'h10 + 8'(7 - i));
      end

      // Collision on port 2 at the top index
      OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd7;
      wr(3'd7, 8'h5A);
      check("coll2_out1", OUT1, 8'h16);
`ifdef REGFILE_BYPASS_EN
      check("coll2_out2", OUT2, 8'h5A);
`else
      check("coll2_out2", OUT2, 8'h17);
`endif
      step();
      check("coll2_next_out2", OUT2, 8'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
